spiflash_responder: RTL and testbench

//  Single-lane SPI flash responder: the device end of the SoC's SPI flash interface, serving READ (0x03) from a byte memory port.

---
 rtl/spiflash_responder.sv | 186 ++++++++++++++++++
 tb/tb_spiflash_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_responder
// Brief    : Single-lane SPI flash device model serving READ (0x03) from a
//            byte memory port; SPI pins oversampled on the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module spiflash_responder #(
  parameter int ADDR_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_csb,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_csb_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_sclk_d, r_rise, r_fall;
  logic                   w_csb, w_sclk, w_mosi;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_bit_cnt, w_cnt_nxt;
  logic [6:0]  r_cmd_sr, w_cmd_nxt;   // opcode byte completes combinationally with the 8th bit
  logic [23:0] r_addr, w_addr_nxt, w_addr_shift;
  logic [7:0]  r_tx, w_tx_nxt;
  logic [7:0]  r_next, w_next_nxt;
  logic [7:0]  w_cmd_byte;
  logic        r_cap;
  logic        r_miso, w_miso_nxt;
  logic        r_miso_oe, w_oe_nxt;
  logic        r_mem_rd, w_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_maddr_nxt;
  logic        r_cmd_err, w_err_nxt;

  assign w_csb  = r_csb_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // csb synchroniser resets to deselected so busy is low straight out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csb_sync  <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
      r_rise      <= w_sclk & ~r_sclk_d;
      r_fall      <= ~w_sclk & r_sclk_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_cmd_sr    <= '0;
      r_addr      <= '0;
      r_tx        <= '0;
      r_next      <= '0;
      r_cap       <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_cmd_sr    <= w_cmd_nxt;
      r_addr      <= w_addr_nxt;
      r_tx        <= w_tx_nxt;
      r_next      <= w_next_nxt;
      r_cap       <= r_mem_rd;
      r_miso      <= w_miso_nxt;
      r_miso_oe   <= w_oe_nxt;
      r_mem_rd    <= w_rd_nxt;
      r_mem_addr  <= w_maddr_nxt;
      r_cmd_err   <= w_err_nxt;
    end
  end

  assign w_cmd_byte   = {r_cmd_sr, w_mosi};
  assign w_addr_shift = {r_addr[22:0], w_mosi};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_cmd_nxt   = r_cmd_sr;
    w_addr_nxt  = r_addr;
    w_tx_nxt    = r_tx;
    w_next_nxt  = r_cap ? mem_rdata : r_next;
    w_miso_nxt  = r_miso;
    w_rd_nxt    = 1'b0;
    w_maddr_nxt = r_mem_addr;
    w_err_nxt   = 1'b0;
    // deselect overrides any edge seen in the same cycle
    if (w_csb) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_miso_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = '0;
        end
        S_CMD: if (r_rise) begin
          w_cmd_nxt = w_cmd_byte[6:0];
          if (r_bit_cnt == 5'd7) begin
            w_cnt_nxt = '0;
            if (w_cmd_byte == 8'h03) begin
              w_state_nxt = S_ADDR;
            end else begin
              w_state_nxt = S_IGNORE;
              w_err_nxt   = (w_cmd_byte != 8'hFF) && (w_cmd_byte != 8'hAB);
            end
          end else begin
            w_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        S_ADDR: if (r_rise) begin
          w_addr_nxt = w_addr_shift;
          if (r_bit_cnt == 5'd23) begin
            w_cnt_nxt   = '0;
            w_rd_nxt    = 1'b1;
            w_maddr_nxt = w_addr_shift[ADDR_W-1:0];
            w_state_nxt = S_DATA;
          end else begin
            w_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        S_DATA: begin
          if (r_fall) begin
            if (r_bit_cnt == 5'd0) begin
              w_miso_nxt = r_next[7];
              w_tx_nxt   = {r_next[6:0], 1'b0};
            end else begin
              w_miso_nxt = r_tx[7];
              w_tx_nxt   = {r_tx[6:0], 1'b0};
            end
            w_cnt_nxt = (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
          end else if (r_rise && (r_bit_cnt == 5'd0)) begin
            // master just sampled bit 0: fetch the following byte
            w_addr_nxt  = r_addr + 24'd1;
            w_rd_nxt    = 1'b1;
            w_maddr_nxt = w_addr_nxt[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
    w_oe_nxt = (w_state_nxt == S_DATA);
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign cmd_err     = r_cmd_err;
  assign busy        = ~w_csb;

endmodule
`default_nettype wire

// File: tb/tb_spiflash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spiflash_responder
// Brief    : Self-checking bench: SPI master driving reads/opcodes against a
//            reference memory model and a byte-stream expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spiflash_responder;
  localparam int ADDR_W = 20;
  localparam int SS     = 2;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              spi_csb = 1'b1;
  logic              spi_clk = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_miso, spi_miso_oe, mem_rd, busy, cmd_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;

  spiflash_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_model(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ {4'h0, a[19:16]};
  endfunction

  // memory with one-cycle read latency plus bus monitors
  logic [ADDR_W-1:0] rd_q[$];
  int  err_count = 0;
  int  oe_count  = 0;
  int  consec_rd = 0;
  bit  prev_rd   = 1'b0;
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem_model(mem_addr);
      rd_q.push_back(mem_addr);
      if (prev_rd) consec_rd++;
    end
    prev_rd <= mem_rd;
    if (cmd_err) err_count++;
    if (spi_miso_oe) oe_count++;
  end

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    rd_q.delete();
    err_count = 0;
    oe_count  = 0;
    spi_csb   = 1'b0;
    half_period();
  endtask

  task automatic frame_end();
    half_period();
    spi_csb  = 1'b1;
    spi_mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic rb);
    spi_mosi = b;
    half_period();
    spi_clk = 1'b1;
    rb = spi_miso;
    half_period();
    spi_clk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], rb);
      rx[i] = rb;
    end
  endtask

  task automatic send_read_hdr(input logic [23:0] a);
    logic [7:0] rx;
    xfer_byte(8'h03, rx);
    xfer_byte(a[23:16], rx);
    xfer_byte(a[15:8], rx);
    xfer_byte(a[7:0], rx);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0]        rx;
    logic [ADDR_W-1:0] ea;
    int                sz;
    frame_begin();
    check("busy_in_frame", busy, 1'b1);
    send_read_hdr(a);
    for (int k = 0; k < n; k++) begin
      ea = ADDR_W'(a + 24'(k));
      xfer_byte(8'h00, rx);
      check("rd_byte", rx, mem_model(ea));
    end
    frame_end();
    sz = rd_q.size();
    check("rd_strobe_count", (sz == n || sz == n + 1), 1'b1);
    for (int k = 0; k < n; k++) begin
      ea = ADDR_W'(a + 24'(k));
      check("rd_addr", (k < sz) ? 32'(rd_q[k]) : 32'hFFFF_FFFF, 32'(ea));
    end
    check("rd_no_cmd_err", err_count, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rx, op;
    logic        rb;
    logic [23:0] ra;
    int          first_k, high_n;

    repeat (3) @(negedge clk);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // basic read and address wrap
    do_read(24'h000010, 4);
    do_read(24'h0FFFFF, 2);

    // power-up/release opcodes are silent
    for (int f = 0; f < 2; f++) begin
      frame_begin();
      xfer_byte((f == 0) ? 8'hFF : 8'hAB, rx);
      xfer_byte(8'h5A, rx);
      frame_end();
      check("silent_cmd_err", err_count, 0);
      check("silent_mem_rd", rd_q.size(), 0);
      check("silent_oe", oe_count, 0);
    end

    // unsupported opcodes: 0x9F then random others
    for (int t = 0; t < 3; t++) begin
      if (t == 0) op = 8'h9F;
      else begin
        do op = 8'($urandom_range(0, 255));
        while (op == 8'h03 || op == 8'hFF || op == 8'hAB);
      end
      frame_begin();
      for (int i = 7; i >= 1; i--) xfer_bit(op[i], rb);
      spi_mosi = op[0];
      half_period();
      spi_clk = 1'b1;
      first_k = -1;
      high_n  = 0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (cmd_err) begin
          high_n++;
          if (first_k < 0) first_k = k;
        end
      end
      spi_clk = 1'b0;
      xfer_byte(8'h00, rx);
      frame_end();
      // SS synchroniser flops, one edge-detect flop, one output flop
      check("err_latency", first_k, SS + 2);
      check("err_width", high_n, 1);
      check("err_oe", oe_count, 0);
      check("err_mem_rd", rd_q.size(), 0);
    end
    do_read(24'h000040, 2);

    // abort after 10 address bits
    frame_begin();
    xfer_byte(8'h03, rx);
    for (int i = 0; i < 10; i++) xfer_bit(i[0], rb);
    frame_end();
    check("abort_mem_rd", rd_q.size(), 0);
    check("abort_busy", busy, 1'b0);
    do_read(24'h000100, 2);

    // randomized reads, upper SPI address bits ignored
    for (int t = 0; t < 4; t++) begin
      ra = 24'($urandom);
      do_read(ra, int'($urandom_range(1, 4)));
    end

    // reset asserted mid-DATA
    frame_begin();
    send_read_hdr(24'h000200);
    xfer_byte(8'h00, rx);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, rb);
    check("pre_reset_oe", spi_miso_oe, 1'b1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_miso", spi_miso, 1'b0);
    check("arst_oe", spi_miso_oe, 1'b0);
    check("arst_mem_rd", mem_rd, 1'b0);
    check("arst_busy", busy, 1'b0);
    spi_csb = 1'b1;
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    do_read(24'h000300, 3);

    check("no_back_to_back_rd", consec_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
